// File: rtl/ws2812b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ws2812b_pkg                                                        |
// | Shared WS2812B receiver state type and 12 MHz line timing.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ws2812b_pkg;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } rx_state_t;

  // Line timing at 12 MHz, common to the driver and the receiver.
  localparam int T0H_CYC   = 5;
  localparam int T1H_CYC   = 10;
  localparam int BIT_CYC   = 15;
  localparam int RESET_CYC = 600;

  localparam int CNT_W = 10;

endpackage
`default_nettype wire

// File: rtl/ws2812b_pulse_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ws2812b_pulse_meter                                                |
// | Synchronises din, measures high/low run lengths, emits bit strobes.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ws2812b_pulse_meter
  import ws2812b_pkg::*;
#(
  parameter int T1_THRESH    = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 14,
  parameter int RESET_CYCLES = RESET_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_rise,
  output logic o_bit_valid,
  output logic o_bit_value,
  output logic o_glitch,
  output logic o_gap
);

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_t1       = CNT_W'(T1_THRESH);
  localparam logic [CNT_W-1:0] c_min_high = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] c_max_high = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] c_too_long = CNT_W'(MAX_HIGH + 1);
  localparam logic [CNT_W-1:0] c_gap      = CNT_W'(RESET_CYCLES - 1);

  logic             r_sync1;
  logic             r_din_s;
  logic             r_din_d;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_lo_cnt;
  logic             w_fall;
  logic             w_too_long;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_din_s  <= 1'b0;
      r_din_d  <= 1'b0;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else begin
      r_sync1 <= i_din;
      r_din_s <= r_sync1;
      r_din_d <= r_din_s;
      // hi_cnt equals the number of high cycles seen so far, so it holds the
      // exact pulse length on the cycle the falling edge is detected.
      if (o_rise)
        r_hi_cnt <= CNT_W'(1);
      else if (r_din_s && r_hi_cnt != c_cnt_max)
        r_hi_cnt <= r_hi_cnt + CNT_W'(1);
      if (r_din_s)
        r_lo_cnt <= '0;
      else if (r_lo_cnt != c_cnt_max)
        r_lo_cnt <= r_lo_cnt + CNT_W'(1);
    end
  end

  assign o_rise      = r_din_s & ~r_din_d;
  assign w_fall      = ~r_din_s & r_din_d;
  assign w_too_long  = r_din_d && (r_hi_cnt == c_too_long);
  assign o_glitch    = (w_fall && (r_hi_cnt < c_min_high)) || w_too_long;
  assign o_bit_valid = w_fall && (r_hi_cnt >= c_min_high) && (r_hi_cnt <= c_max_high);
  assign o_bit_value = (r_hi_cnt >= c_t1);
  assign o_gap       = ~r_din_s && (r_lo_cnt == c_gap);

endmodule
`default_nettype wire

// File: rtl/ws2812b_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ws2812b_rx                                                         |
// | WS2812B NRZ receiver: assembles GRB pixels and detects frame ends. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int T1_THRESH    = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 14,
  parameter int RESET_CYCLES = RESET_CYC,
  parameter int NUM_PIXELS   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din,
  output logic                          pixel_valid,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel_index,
  output logic                          frame_done,
  output logic [$clog2(NUM_PIXELS):0]   frame_pixels,
  output logic                          bit_error,
  output logic                          overflow
);

  localparam int PIX_W = $clog2(NUM_PIXELS);
  localparam logic [PIX_W:0] c_num_pix = NUM_PIXELS[PIX_W:0];

  rx_state_t      r_state;
  rx_state_t      w_state_next;
  logic           w_rise;
  logic           w_bit_valid;
  logic           w_bit_value;
  logic           w_glitch;
  logic           w_gap;
  logic           w_shift;
  logic           w_err;
  logic           w_frame_end;

  logic [23:0]    r_sr;
  logic [4:0]     r_bit_cnt;
  logic [PIX_W:0] r_pix_cnt;
  logic           r_pend;

  ws2812b_pulse_meter #(
    .T1_THRESH   (T1_THRESH),
    .MIN_HIGH    (MIN_HIGH),
    .MAX_HIGH    (MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .i_din      (din),
    .o_rise     (w_rise),
    .o_bit_valid(w_bit_valid),
    .o_bit_value(w_bit_value),
    .o_glitch   (w_glitch),
    .o_gap      (w_gap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_GAP;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_err        = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      WAIT_GAP: if (w_gap) w_state_next = IDLE;
      IDLE:     if (w_rise) w_state_next = HIGH;
      HIGH: begin
        if (w_glitch) begin
          w_err        = 1'b1;
          w_state_next = WAIT_GAP;
        end else if (w_bit_valid) begin
          w_shift      = 1'b1;
          w_state_next = LOW;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
        end else if (w_gap) begin
          w_frame_end  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_pend       <= 1'b0;
      pixel_valid  <= 1'b0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_error    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      r_pend      <= 1'b0;
      if (frame_done)
        overflow <= 1'b0;

      // An error abandons the frame in progress; decoding restarts after a gap.
      if (w_err) begin
        bit_error <= 1'b1;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
      end else if (w_shift) begin
        r_sr <= {r_sr[22:0], w_bit_value};
        if (r_bit_cnt == 5'd23) begin
          r_bit_cnt <= '0;
          r_pend    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end

      if (r_pend && !w_err) begin
        if (r_pix_cnt == c_num_pix) begin
          overflow <= 1'b1;
        end else begin
          pixel_valid <= 1'b1;
          green       <= r_sr[23:16];
          red         <= r_sr[15:8];
          blue        <= r_sr[7:0];
          pixel_index <= r_pix_cnt[PIX_W-1:0];
          r_pix_cnt   <= r_pix_cnt + 1'b1;
        end
      end

      if (w_frame_end) begin
        if (r_bit_cnt != 5'd0)
          bit_error <= 1'b1;
        if (r_pix_cnt != '0) begin
          frame_done   <= 1'b1;
          frame_pixels <= r_pix_cnt;
        end
        r_pix_cnt <= '0;
        r_bit_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ws2812b_rx                                                      |
// | Randomised frame stimulus against a queue-based pixel/frame model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ws2812b_rx;

  localparam int NPIX = 64;
  localparam int GAP  = 700;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       pixel_valid;
  logic [7:0] red, green, blue;
  logic [5:0] pixel_index;
  logic       frame_done;
  logic [6:0] frame_pixels;
  logic       bit_error;
  logic       overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [29:0] q_got[$];
  logic [23:0] q_sent[$];
  int          n_fd = 0;
  int          n_be = 0;
  logic [6:0]  last_fp = '0;
  logic        ovf_prev = 1'b0;
  logic        ovf_at_fd = 1'b0;

  always #5 clk = ~clk;

  ws2812b_rx #(
    .T1_THRESH   (7),
    .MIN_HIGH    (2),
    .MAX_HIGH    (14),
    .RESET_CYCLES(600),
    .NUM_PIXELS  (NPIX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .pixel_valid (pixel_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .bit_error   (bit_error),
    .overflow    (overflow)
  );

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (pixel_valid) q_got.push_back({pixel_index, green, red, blue});
    if (frame_done) begin
      n_fd++;
      last_fp   = frame_pixels;
      ovf_at_fd = ovf_prev;
    end
    if (bit_error) n_be++;
    ovf_prev = overflow;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // Nominal timing when fixed, otherwise random within the legal windows.
  task automatic send_bit(input logic b, input bit fixed);
    int h, l;
    if (fixed) begin
      h = b ? 10 : 4;
      l = b ? 5 : 11;
    end else begin
      h = b ? int'($urandom_range(14, 7)) : int'($urandom_range(6, 2));
      l = int'($urandom_range(5, 2));
    end
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic send_pixel(input logic [23:0] grb, input bit fixed);
    for (int i = 23; i >= 0; i--) send_bit(grb[i], fixed);
  endtask

  task automatic clear_mon();
    q_got.delete();
    q_sent.delete();
    n_fd      = 0;
    n_be      = 0;
    last_fp   = '0;
    ovf_at_fd = 1'b0;
  endtask

  task automatic send_frame(input bit fixed);
    foreach (q_sent[i]) send_pixel(q_sent[i], fixed);
    hold(1'b0, GAP);
  endtask

  // Model: first min(n, NPIX) pixels come back in order with their index,
  // one frame_done carrying that count, overflow only when n exceeds NPIX.
  task automatic check_frame(input string tag);
    int n;
    int n_exp;
    n     = q_sent.size();
    n_exp = (n > NPIX) ? NPIX : n;
    chk($sformatf("%s_count", tag), q_got.size(), n_exp);
    for (int i = 0; i < n_exp && i < q_got.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), 32'(q_got[i][29:24]), i);
      chk($sformatf("%s_grb%0d", tag, i), 32'(q_got[i][23:0]), 32'(q_sent[i]));
    end
    chk($sformatf("%s_fd", tag), n_fd, (n > 0) ? 1 : 0);
    chk($sformatf("%s_fp", tag), 32'(last_fp), n_exp);
    chk($sformatf("%s_be", tag), n_be, 0);
    chk($sformatf("%s_ovf_at_fd", tag), 32'(ovf_at_fd), (n > NPIX) ? 1 : 0);
    chk($sformatf("%s_ovf_after", tag), 32'(overflow), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pv"}, 32'(pixel_valid), 0);
    chk({tag, "_red"}, 32'(red), 0);
    chk({tag, "_green"}, 32'(green), 0);
    chk({tag, "_blue"}, 32'(blue), 0);
    chk({tag, "_idx"}, 32'(pixel_index), 0);
    chk({tag, "_fd"}, 32'(frame_done), 0);
    chk({tag, "_fp"}, 32'(frame_pixels), 0);
    chk({tag, "_be"}, 32'(bit_error), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    hold(1'b0, GAP);

    clear_mon();
    q_sent.push_back(24'h00FF00);
    send_frame(1'b1);
    check_frame("single");

    clear_mon();
    for (int k = 0; k < 64; k++) q_sent.push_back({8'(k), ~8'(k), 8'hA5});
    send_frame(1'b0);
    check_frame("full64");

    clear_mon();
    for (int k = 0; k < 65; k++) q_sent.push_back({8'(k), ~8'(k), 8'hA5});
    send_frame(1'b0);
    check_frame("over65");

    clear_mon();
    for (int k = 0; k < int'($urandom_range(10, 1)); k++) q_sent.push_back(24'($urandom));
    send_frame(1'b0);
    check_frame("rand");

    // Partial pixel cut short by a latch gap.
    clear_mon();
    for (int k = 0; k < 12; k++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    hold(1'b0, GAP);
    chk("partial_be", n_be, 1);
    chk("partial_pv", q_got.size(), 0);
    chk("partial_fd", n_fd, 0);
    clear_mon();
    for (int k = 0; k < 3; k++) q_sent.push_back(24'($urandom));
    send_frame(1'b0);
    check_frame("after_partial");

    // Short glitch, ignored data, gap, then an over-long high.
    clear_mon();
    for (int k = 0; k < 8; k++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    hold(1'b1, 1);
    hold(1'b0, 6);
    chk("glitch_short_be", n_be, 1);
    for (int k = 0; k < 6; k++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    hold(1'b0, GAP);
    for (int k = 0; k < 5; k++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    hold(1'b1, 20);
    hold(1'b0, 6);
    chk("glitch_long_be", n_be, 2);
    for (int k = 0; k < 4; k++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    hold(1'b0, GAP);
    chk("glitch_pv", q_got.size(), 0);
    chk("glitch_fd", n_fd, 0);
    chk("glitch_be_total", n_be, 2);
    clear_mon();
    for (int k = 0; k < 2; k++) q_sent.push_back(24'($urandom));
    send_frame(1'b0);
    check_frame("resume");

    // Reset in the middle of a frame.
    clear_mon();
    for (int k = 0; k < 40; k++) q_sent.push_back(24'($urandom) | 24'h010101);
    foreach (q_sent[i]) send_pixel(q_sent[i], 1'b0);
    hold(1'b0, 4);
    chk("pre_rst_count", q_got.size(), 40);
    if (q_got.size() == 40) chk("pre_rst_last", 32'(q_got[39]), 32'({6'd39, q_sent[39]}));
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 5; k++) send_pixel(24'($urandom), 1'b0);
    hold(1'b0, GAP);
    chk("post_rst_pv", q_got.size(), 0);
    chk("post_rst_fd", n_fd, 0);
    chk("post_rst_be", n_be, 0);
    clear_mon();
    q_sent.push_back(24'($urandom));
    send_frame(1'b0);
    check_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
